// File: rtl/mem_arb_pkg.sv
// Shared types and line geometry for the L1 miss arbiter.
// Also used by the Icache and Dcache for refill sizing.
package mem_arb_pkg;

    typedef enum logic {
        SRC_IC = 1'b0,
        SRC_DC = 1'b1
    } src_e;

    localparam int unsigned LINE_SIZE    = 512;
    localparam int unsigned OFFSET_WIDTH = 6;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Cache-side and memory-side handshake bundle of mem_req_arbiter.
// slave: arbiter view; master: the surrounding caches and memory.
interface mem_req_arbiter_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int LINE_SIZE  = 512
);
    logic                  ic_req_valid_i;
    logic                  ic_req_ready_o;
    logic [ADDR_WIDTH-1:0] ic_req_addr_i;
    logic                  dc_req_valid_i;
    logic                  dc_req_ready_o;
    logic [ADDR_WIDTH-1:0] dc_req_addr_i;
    logic                  mem_req_valid_o;
    logic                  mem_req_ready_i;
    logic [ADDR_WIDTH-1:0] mem_req_addr_o;
    logic                  mem_resp_valid_i;
    logic                  mem_resp_ready_o;
    logic [LINE_SIZE-1:0]  mem_resp_data_i;
    logic                  ic_refill_valid_o;
    logic                  ic_refill_ready_i;
    logic [LINE_SIZE-1:0]  ic_refill_data_o;
    logic                  dc_refill_valid_o;
    logic                  dc_refill_ready_i;
    logic [LINE_SIZE-1:0]  dc_refill_data_o;

    modport slave (
        input  ic_req_valid_i, ic_req_addr_i,
        output ic_req_ready_o,
        input  dc_req_valid_i, dc_req_addr_i,
        output dc_req_ready_o,
        output mem_req_valid_o, mem_req_addr_o,
        input  mem_req_ready_i,
        input  mem_resp_valid_i, mem_resp_data_i,
        output mem_resp_ready_o,
        output ic_refill_valid_o, ic_refill_data_o,
        input  ic_refill_ready_i,
        output dc_refill_valid_o, dc_refill_data_o,
        input  dc_refill_ready_i
    );

    modport master (
        output ic_req_valid_i, ic_req_addr_i,
        input  ic_req_ready_o,
        output dc_req_valid_i, dc_req_addr_i,
        input  dc_req_ready_o,
        input  mem_req_valid_o, mem_req_addr_o,
        output mem_req_ready_i,
        output mem_resp_valid_i, mem_resp_data_i,
        input  mem_resp_ready_o,
        input  ic_refill_valid_o, ic_refill_data_o,
        output ic_refill_ready_i,
        input  dc_refill_valid_o, dc_refill_data_o,
        output dc_refill_ready_i
    );
endinterface

// File: rtl/mem_arb_src_fifo.sv
// In-order FIFO of request source IDs, one entry per issued read.
// DEPTH must be a power of two so the pointers wrap naturally.
module mem_arb_src_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int PTR_WIDTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push_i,
    input  src_e               push_src_i,
    input  logic               pop_i,
    output src_e               head_src_o,
    output logic [PTR_WIDTH:0] count_o
);
    src_e                 mem_q [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr_q;
    logic [PTR_WIDTH-1:0] rd_ptr_q;
    logic [PTR_WIDTH:0]   cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= SRC_IC;
            end
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_src_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            cnt_q <= cnt_q
                   + {{PTR_WIDTH{1'b0}}, push_i}
                   - {{PTR_WIDTH{1'b0}}, pop_i};
        end
    end

    assign head_src_o = mem_q[rd_ptr_q];
    assign count_o    = cnt_q;
endmodule

// File: rtl/mem_req_arbiter.sv
// Icache/Dcache miss arbiter onto the single memory read port.
// MEM_ARB_ICACHE_PRIO_EN: fixed Icache priority instead of round-robin.
module mem_req_arbiter #(
    parameter int ADDR_WIDTH    = 64,
    parameter int LINE_SIZE     = 512,
    parameter int OFFSET_WIDTH  = 6,
    parameter int OST_DEPTH     = 4,
    parameter int OST_PTR_WIDTH = 2
) (
    input logic              clk,
    input logic              rst_n,
    mem_req_arbiter_if.slave bus
);
    import mem_arb_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        {{(ADDR_WIDTH-OFFSET_WIDTH){1'b1}}, {OFFSET_WIDTH{1'b0}}};
    localparam logic [OST_PTR_WIDTH:0] OST_FULL =
        (OST_PTR_WIDTH+1)'(OST_DEPTH);

    logic                  req_vld_q, req_vld_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic                  resp_vld_q, resp_vld_d;
    src_e                  resp_src_q, resp_src_d;
    logic [LINE_SIZE-1:0]  resp_data_q, resp_data_d;

    logic [OST_PTR_WIDTH:0] ost_cnt;
    src_e                   head_src;
    logic                   slot_free, can_grant;
    logic                   ic_win, dc_win, ic_gnt, dc_gnt, grant;
    src_e                   gnt_src;
    logic [ADDR_WIDTH-1:0]  gnt_addr;
    logic                   tgt_rdy, resp_rdy, resp_acc;

`ifndef MEM_ARB_ICACHE_PRIO_EN
    src_e last_grant_q, last_grant_d;
`endif

    always_comb begin
        ic_win = 1'b0;
        dc_win = 1'b0;
        unique case (1'b1)
            bus.ic_req_valid_i && !bus.dc_req_valid_i: ic_win = 1'b1;
            bus.dc_req_valid_i && !bus.ic_req_valid_i: dc_win = 1'b1;
            bus.ic_req_valid_i && bus.dc_req_valid_i: begin
`ifdef MEM_ARB_ICACHE_PRIO_EN
                ic_win = 1'b1;
`else
                ic_win = (last_grant_q == SRC_DC);
                dc_win = (last_grant_q == SRC_IC);
`endif
            end
            default: ;
        endcase
    end

    // Count includes the request still parked in the slot.
    assign slot_free = !req_vld_q || bus.mem_req_ready_i;
    assign can_grant = slot_free && (ost_cnt != OST_FULL);
    assign ic_gnt    = can_grant && ic_win;
    assign dc_gnt    = can_grant && dc_win;
    assign grant     = ic_gnt || dc_gnt;
    assign gnt_src   = dc_gnt ? SRC_DC : SRC_IC;
    assign gnt_addr  = dc_gnt ? bus.dc_req_addr_i : bus.ic_req_addr_i;

    assign tgt_rdy  = (resp_src_q == SRC_IC) ? bus.ic_refill_ready_i
                                             : bus.dc_refill_ready_i;
    assign resp_rdy = (ost_cnt != '0) && (!resp_vld_q || tgt_rdy);
    assign resp_acc = bus.mem_resp_valid_i && resp_rdy;

    always_comb begin
        req_vld_d   = req_vld_q;
        req_addr_d  = req_addr_q;
        resp_vld_d  = resp_vld_q;
        resp_src_d  = resp_src_q;
        resp_data_d = resp_data_q;
        if (grant) begin
            req_vld_d  = 1'b1;
            req_addr_d = gnt_addr & ALIGN_MASK;
        end else if (bus.mem_req_ready_i) begin
            req_vld_d = 1'b0;
        end
        if (resp_acc) begin
            resp_vld_d  = 1'b1;
            resp_src_d  = head_src;
            resp_data_d = bus.mem_resp_data_i;
        end else if (resp_vld_q && tgt_rdy) begin
            resp_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_vld_q   <= 1'b0;
            req_addr_q  <= '0;
            resp_vld_q  <= 1'b0;
            resp_src_q  <= SRC_IC;
            resp_data_q <= '0;
        end else begin
            req_vld_q   <= req_vld_d;
            req_addr_q  <= req_addr_d;
            resp_vld_q  <= resp_vld_d;
            resp_src_q  <= resp_src_d;
            resp_data_q <= resp_data_d;
        end
    end

`ifndef MEM_ARB_ICACHE_PRIO_EN
    assign last_grant_d = grant ? gnt_src : last_grant_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= SRC_DC;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    mem_arb_src_fifo #(
        .DEPTH     (OST_DEPTH),
        .PTR_WIDTH (OST_PTR_WIDTH)
    ) u_src_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (grant),
        .push_src_i (gnt_src),
        .pop_i      (resp_acc),
        .head_src_o (head_src),
        .count_o    (ost_cnt)
    );

    assign bus.ic_req_ready_o    = ic_gnt;
    assign bus.dc_req_ready_o    = dc_gnt;
    assign bus.mem_req_valid_o   = req_vld_q;
    assign bus.mem_req_addr_o    = req_addr_q;
    assign bus.mem_resp_ready_o  = resp_rdy;
    assign bus.ic_refill_valid_o = resp_vld_q && (resp_src_q == SRC_IC);
    assign bus.dc_refill_valid_o = resp_vld_q && (resp_src_q == SRC_DC);
    assign bus.ic_refill_data_o  = resp_data_q;
    assign bus.dc_refill_data_o  = resp_data_q;
endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Shares the single line-granular memory read port between the Icache miss path and the Dcache miss path. It arbitrates competing miss requests and forwards one request at a time to memory with a registered, stable output. It records the source of every issued request in an in-order outstanding FIFO, so each 512-bit refill response is steered back to the cache that requested it. It sits between the L1 caches and the memory subsystem, replacing direct cache-to-memory miss wiring.

## Interface
- ADDR_WIDTH, 64: request address width
- LINE_SIZE, 512: refill line width in bits
- OFFSET_WIDTH, 6: line offset bits, forced to zero on memory address
- OST_DEPTH, 4: maximum outstanding memory reads, power of two
- OST_PTR_WIDTH, 2: log2(OST_DEPTH)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- ic_req_valid_i  in  1  Icache miss request
- ic_req_ready_o  out  1  Icache request accepted
- ic_req_addr_i  in  ADDR_WIDTH  Icache miss address
- dc_req_valid_i  in  1  Dcache miss request
- dc_req_ready_o  out  1  Dcache request accepted
- dc_req_addr_i  in  ADDR_WIDTH  Dcache miss address
- mem_req_valid_o  out  1  request to memory
- mem_req_ready_i  in  1  memory accepts request
- mem_req_addr_o  out  ADDR_WIDTH  line-aligned address
- mem_resp_valid_i  in  1  refill line from memory
- mem_resp_ready_o  out  1  arbiter accepts refill
- mem_resp_data_i  in  LINE_SIZE  refill data
- ic_refill_valid_o  out  1  refill to Icache
- ic_refill_ready_i  in  1  Icache accepts refill
- ic_refill_data_o  out  LINE_SIZE  refill data to Icache
- dc_refill_valid_o  out  1  refill to Dcache
- dc_refill_ready_i  in  1  Dcache accepts refill
- dc_refill_data_o  out  LINE_SIZE  refill data to Dcache

## Operation
- **Request slot:** a one-entry register that drives mem_req_valid_o and mem_req_addr_o.
  - slot_free = !mem_req_valid_o || mem_req_ready_i.
  - Address and valid hold stable while valid is high and ready is low.
- **Grant condition:** a grant is made only when slot_free && ost_cnt < OST_DEPTH.
  - ost_cnt is sampled before any same-cycle pop. At full, a simultaneous pop does not enable a grant that cycle.
- **Ready outputs:** ic_req_ready_o and dc_req_ready_o are combinational: grant condition AND the source wins arbitration. At most one is high per cycle.
- **Arbitration (round-robin):**
  - A single requester wins outright.
  - When both request, the source that is not last_grant wins.
  - last_grant updates on every grant. Its reset value is DC, so the first tie goes to IC.
- **Grant action:**
  - Load the slot with {addr[ADDR_WIDTH-1:OFFSET_WIDTH], OFFSET_WIDTH'b0}.
  - Push the source ID into the outstanding FIFO and increment ost_cnt. The count therefore includes the request still waiting in the slot.
- **Response path:**
  - One-entry response buffer: resp_vld, resp_src, resp_data.
  - mem_resp_ready_o = ost_cnt != 0 && (!resp_vld || selected target ready).
  - A response accepted while the FIFO is empty is impossible, because ready is low.
- **Response acceptance:** pop the FIFO head into resp_src, capture the data, decrement ost_cnt.
  - Simultaneous grant and pop leaves ost_cnt unchanged.
- **Refill outputs:**
  - ic_refill_valid_o = resp_vld && resp_src == IC; dc_refill_valid_o = resp_vld && resp_src == DC.
  - Both data outputs carry resp_data.
  - Buffer clears on target ready unless a new response is loaded the same cycle. Back-to-back responses give full throughput.
- **Ordering:** responses are in order; memory returns them in issue order.
- **Squash:** there is no squash input. Outstanding Icache refills are always delivered.

## Timing
- Reset values:
  - all valid outputs 0
  - mem_req_addr_o 0; refill data outputs 0
  - ost_cnt 0; FIFO pointers 0; last_grant DC
- Reset asserted mid-operation discards all outstanding state immediately.
- Request latency: accepted at cycle N (valid && ready), so mem_req_valid_o is high from N+1.
- Refill latency: memory response accepted at cycle M, so the refill valid output is high from M+1.
- Sustained issue rate is one request per cycle when mem_req_ready_i is held high and ost_cnt < OST_DEPTH.
- FIFO pointers wrap modulo OST_DEPTH.

## Configuration
- MEM_ARB_ICACHE_PRIO_EN defined:
  - fixed priority; Icache always wins a tie
  - last_grant register omitted
- Not defined: round-robin as described above.
- The macro has no other effect.

## Structure
- Package mem_arb_pkg holds:
  - src_e enum: SRC_IC = 1'b0, SRC_DC = 1'b1
  - LINE_SIZE and OFFSET_WIDTH constants, shared with Icache and Dcache
- One sub-module: mem_arb_src_fifo, a synchronous source-ID FIFO.
  - Parameters: DEPTH, PTR_WIDTH.
  - Ports: push, push_src, pop, head_src, count.

## Test plan
- Single IC miss at 0x1234, memory ready:
  - mem_req_addr_o = 0x1200 on the next cycle.
  - Response data 0xA5… returns as ic_refill_valid_o with that data, one cycle after acceptance.
- IC and DC both valid every cycle with mem ready: grants alternate IC, DC, IC, DC (IC first after reset). With MEM_ARB_ICACHE_PRIO_EN, all grants go to IC.
- mem_req_ready_i low for 5 cycles: mem_req_valid_o and mem_req_addr_o stay constant, and no further grant occurs.
- Issue 4 requests without responses:
  - ost_cnt = 4 and both ready outputs stay 0.
  - Returning one response with a same-cycle request gives no grant that cycle; the grant follows the next cycle.
- Order IC, DC, IC issued, then 3 responses D0, D1, D2: D0 goes to IC, D1 to DC, D2 to IC.
- DC refill with dc_refill_ready_i low:
  - mem_resp_ready_o stays 0 for the next response while the buffer is occupied.
  - Releasing ready delivers both responses in order.
- rst_n pulsed low with 2 outstanding requests: all valid outputs drop to 0 and ost_cnt = 0.
